// File: rtl/l2_pkg.sv
// l2_pkg: shared constants and FSM state encoding for the L2 memory adapter.
package l2_pkg;
    localparam int L2_LINE_W  = 256;
    localparam int L2_BURST_W = 64;
    localparam int L2_ADDR_W  = 32;
    localparam int L2_BEATS   = L2_LINE_W / L2_BURST_W;
    localparam int L2_OFF_W   = $clog2(L2_LINE_W / 8);
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FILL  = 2'd1;
    localparam state_t ST_WBACK = 2'd2;
    localparam state_t ST_DONE  = 2'd3;
endpackage

// File: rtl/l2_mem_adapter.sv
// l2_mem_adapter: bridges L2 line fill/writeback requests to a beat-wise burst memory.
// Defining L2_ADAPTER_PERF_EN adds fill_count_o / wback_count_o completion counters.
module l2_mem_adapter
    import l2_pkg::*;
#(
    parameter int LINE_W  = L2_LINE_W,
    parameter int BURST_W = L2_BURST_W,
    parameter int ADDR_W  = L2_ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               read_i,
    input  logic               write_i,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    output logic               resp_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic [ADDR_W-1:0]  mem_address_o,
    output logic [BURST_W-1:0] mem_wdata_o,
`ifdef L2_ADAPTER_PERF_EN
    output logic [31:0]        fill_count_o,
    output logic [31:0]        wback_count_o,
`endif
    input  logic [BURST_W-1:0] mem_rdata_i,
    input  logic               mem_resp_i
);
    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LINE_W-1:0]  wline_q, line_q;
    logic               idle, busy, last, accept, beat;

    assign idle   = state_q == ST_IDLE;
    assign busy   = state_q == ST_FILL || state_q == ST_WBACK;
    assign last   = cnt_q == CNT_W'(BEATS - 1);
    assign accept = idle && (read_i || write_i);
    assign beat   = busy && mem_resp_i;

    always_comb begin
        state_d = idle ? (write_i ? ST_WBACK : read_i ? ST_FILL : ST_IDLE) :
                  state_q == ST_DONE ? ST_IDLE :
                  beat && last ? ST_DONE : state_q;
    end

    assign line_o        = line_q;
    assign resp_o        = state_q == ST_DONE;
    assign mem_read_o    = state_q == ST_FILL;
    assign mem_write_o   = state_q == ST_WBACK;
    assign mem_address_o = addr_q;
    assign mem_wdata_o   = mem_write_o ? wline_q[int'(cnt_q) * BURST_W +: BURST_W] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= address_i & ~OFF_MASK;
                cnt_q  <= '0;
                if (write_i)
                    wline_q <= line_i;
            end else if (beat) begin
                cnt_q <= last ? '0 : cnt_q + 1'b1;
                if (mem_read_o)
                    line_q[int'(cnt_q) * BURST_W +: BURST_W] <= mem_rdata_i;
            end
        end
    end

`ifdef L2_ADAPTER_PERF_EN
    logic [31:0] fill_q, wback_q;

    assign fill_count_o  = fill_q;
    assign wback_count_o = wback_q;

    // Counted on the edge entering DONE so the new value is visible alongside resp_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q  <= '0;
            wback_q <= '0;
        end else if (beat && last) begin
            fill_q  <= fill_q + {31'd0, mem_read_o};
            wback_q <= wback_q + {31'd0, mem_write_o};
        end
    end
`endif
endmodule

// File: tb/tb_l2_mem_adapter.sv
// tb_l2_mem_adapter: randomized self-checking bench for l2_mem_adapter against a line-level model.
module tb_l2_mem_adapter;
    localparam int BEATS = 4;

    logic         clk = 1'b0;
    logic         rst, read_i, write_i, mem_resp_i;
    logic [31:0]  address_i, mem_address_o;
    logic [255:0] line_i, line_o;
    logic         resp_o, mem_read_o, mem_write_o;
    logic [63:0]  mem_wdata_o, mem_rdata_i;
`ifdef L2_ADAPTER_PERF_EN
    logic [31:0]  fill_count_o, wback_count_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    l2_mem_adapter dut (
        .clk(clk), .rst(rst), .read_i(read_i), .write_i(write_i),
        .address_i(address_i), .line_i(line_i), .line_o(line_o), .resp_o(resp_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_address_o(mem_address_o),
        .mem_wdata_o(mem_wdata_o),
`ifdef L2_ADAPTER_PERF_EN
        .fill_count_o(fill_count_o), .wback_count_o(wback_count_o),
`endif
        .mem_rdata_i(mem_rdata_i), .mem_resp_i(mem_resp_i)
    );

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One request from acceptance to the DONE cycle; returns what the memory side observed.
    task automatic xfer(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [255:0] wl, input logic [255:0] rdl,
                        input int minw, input int maxw, input logic spur,
                        output int lat, output int tw, output logic [255:0] got,
                        output logic [255:0] wseq, output int unstable,
                        output logic saw_rd, output logic saw_wr, output logic [31:0] maddr);
        int k, w;
        logic newbeat;
        logic [63:0] hold;
        @(negedge clk);
        read_i = rd; write_i = wr; address_i = addr; line_i = wl; mem_resp_i = 1'b0;
        lat = 0; tw = 0; unstable = 0; saw_rd = 1'b0; saw_wr = 1'b0; wseq = '0; k = 0;
        newbeat = 1'b1; hold = '0;
        @(negedge clk);
        lat = 1;
        address_i = $urandom;
        line_i = rand_line();
        maddr = mem_address_o;
        w = $urandom_range(maxw, minw);
        tw += w;
        while (!resp_o && lat < 100) begin
            saw_rd |= mem_read_o;
            saw_wr |= mem_write_o;
            if (newbeat) hold = mem_wdata_o;
            newbeat = 1'b0;
            if (mem_wdata_o !== hold) unstable++;
            if (w == 0) begin
                mem_resp_i = 1'b1;
                mem_rdata_i = k < BEATS ? rdl[k*64 +: 64] : 64'd0;
                if (k < BEATS) wseq[k*64 +: 64] = mem_wdata_o;
                k++;
                newbeat = 1'b1;
                if (k < BEATS) begin
                    w = $urandom_range(maxw, minw);
                    tw += w;
                end
            end else begin
                mem_resp_i = 1'b0;
                mem_rdata_i = {$urandom, $urandom};
                w--;
            end
            @(negedge clk);
            lat++;
        end
        got = line_o;
        read_i = 1'b0; write_i = 1'b0;
        mem_resp_i = spur;
        mem_rdata_i = {$urandom, $urandom};
    endtask

    task automatic test_reset();
        rst = 1'b1; read_i = 1'b0; write_i = 1'b0; mem_resp_i = 1'b0;
        address_i = '0; line_i = '0; mem_rdata_i = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({resp_o, mem_read_o, mem_write_o, mem_address_o, mem_wdata_o, line_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs resp=%b rd=%b wr=%b addr=%h wdata=%h line=%h exp all zero",
                     resp_o, mem_read_o, mem_write_o, mem_address_o, mem_wdata_o, line_o);
        end
`ifdef L2_ADAPTER_PERF_EN
        total++;
        if ({fill_count_o, wback_count_o} !== 64'd0) begin
            bad++;
            $display("FAIL reset_counters got=%0d/%0d exp=0/0", fill_count_o, wback_count_o);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_fill();
        int lat, tw, un;
        logic [255:0] rdl, got, ws;
        logic srd, swr;
        logic [31:0] ma;
        rdl = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        xfer(1'b0, 1'b1, 32'h0000_1234, '0, rdl, 0, 0, 1'b0, lat, tw, got, ws, un, srd, swr, ma);
        total++;
        if (ma !== 32'h0000_1220) begin bad++; $display("FAIL fill_addr got=%h exp=00001220", ma); end
        total++;
        if (lat !== BEATS + 1) begin bad++; $display("FAIL fill_latency got=%0d exp=%0d", lat, BEATS + 1); end
        total++;
        if (got !== rdl) begin bad++; $display("FAIL fill_line got=%h exp=%h", got, rdl); end
        total++;
        if (swr !== 1'b0) begin bad++; $display("FAIL fill_no_write got=%b exp=0", swr); end
        @(negedge clk);
        total++;
        if ({resp_o, line_o} !== {1'b0, rdl}) begin
            bad++;
            $display("FAIL fill_after resp=%b line=%h exp resp=0 line=%h", resp_o, line_o, rdl);
        end
    endtask

    task automatic test_wback();
        int lat, tw, un;
        logic [255:0] wl, got, ws, prev;
        logic srd, swr;
        logic [31:0] ma;
        prev = line_o;
        wl = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        xfer(1'b1, 1'b0, 32'h0000_8000, wl, '0, 2, 2, 1'b0, lat, tw, got, ws, un, srd, swr, ma);
        total++;
        if (ws !== wl) begin bad++; $display("FAIL wback_beats got=%h exp=%h", ws, wl); end
        total++;
        if (un !== 0) begin bad++; $display("FAIL wback_stable got=%0d changes exp=0", un); end
        total++;
        if (lat !== 1 + BEATS + 2 * BEATS) begin
            bad++; $display("FAIL wback_latency got=%0d exp=%0d", lat, 1 + 3 * BEATS);
        end
        total++;
        if (got !== prev) begin bad++; $display("FAIL wback_line_hold got=%h exp=%h", got, prev); end
        @(negedge clk);
        total++;
        if (resp_o !== 1'b0) begin bad++; $display("FAIL wback_resp_once got=%b exp=0", resp_o); end
    endtask

    task automatic test_both();
        int lat, tw, un;
        logic [255:0] wl, got, ws;
        logic srd, swr;
        logic [31:0] ma;
        wl = rand_line();
        xfer(1'b1, 1'b1, $urandom, wl, rand_line(), 0, 1, 1'b0, lat, tw, got, ws, un, srd, swr, ma);
        total++;
        if ({srd, swr} !== 2'b01) begin bad++; $display("FAIL both_priority rd=%b wr=%b exp rd=0 wr=1", srd, swr); end
        total++;
        if (ws !== wl) begin bad++; $display("FAIL both_beats got=%h exp=%h", ws, wl); end
    endtask

    task automatic test_spurious();
        int lat, tw, un;
        logic [255:0] rdl, got, ws;
        logic srd, swr;
        logic [31:0] ma;
        rdl = rand_line();
        xfer(1'b0, 1'b1, $urandom, '0, rdl, 0, 1, 1'b1, lat, tw, got, ws, un, srd, swr, ma);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({resp_o, mem_read_o, mem_write_o, line_o} !== {3'b000, rdl}) begin
                bad++;
                $display("FAIL spurious_%0d resp=%b rd=%b wr=%b line=%h exp 0/0/0 line=%h",
                         i, resp_o, mem_read_o, mem_write_o, line_o, rdl);
            end
            mem_rdata_i = {$urandom, $urandom};
        end
        mem_resp_i = 1'b0;
    endtask

    task automatic test_rst_mid();
        int lat, tw, un;
        logic [255:0] rdl, got, ws;
        logic srd, swr;
        logic [31:0] ma, addr;
        @(negedge clk);
        read_i = 1'b1; address_i = $urandom; mem_resp_i = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            mem_resp_i = 1'b1; mem_rdata_i = {$urandom, $urandom};
            @(negedge clk);
        end
        rst = 1'b1; read_i = 1'b0;
        @(negedge clk);
        total++;
        if ({resp_o, mem_read_o, mem_write_o, mem_address_o, mem_wdata_o, line_o} !== '0) begin
            bad++;
            $display("FAIL rst_mid resp=%b rd=%b wr=%b addr=%h line=%h exp all zero",
                     resp_o, mem_read_o, mem_write_o, mem_address_o, line_o);
        end
        rst = 1'b0; mem_resp_i = 1'b0;
        rdl = rand_line();
        addr = $urandom;
        xfer(1'b0, 1'b1, addr, '0, rdl, 0, 2, 1'b0, lat, tw, got, ws, un, srd, swr, ma);
        total++;
        if (got !== rdl) begin bad++; $display("FAIL rst_refill_line got=%h exp=%h", got, rdl); end
        total++;
        if (ma !== {addr[31:5], 5'd0}) begin bad++; $display("FAIL rst_refill_addr got=%h exp=%h", ma, {addr[31:5], 5'd0}); end
    endtask

    task automatic test_back_to_back();
        int lat, tw, un;
        logic [255:0] wl, rdl, got, ws, last_fill;
        logic srd, swr, wr;
        logic [31:0] ma, addr;
        last_fill = line_o;
        for (int n = 0; n < 10; n++) begin
            wr = $urandom_range(1, 0);
            wl = rand_line(); rdl = rand_line(); addr = $urandom;
            xfer(wr, !wr, addr, wl, rdl, 0, 3, 1'b0, lat, tw, got, ws, un, srd, swr, ma);
            if (!wr) last_fill = rdl;
            total++;
            if (lat !== 1 + BEATS + tw) begin bad++; $display("FAIL b2b%0d_latency got=%0d exp=%0d", n, lat, 1 + BEATS + tw); end
            total++;
            if (got !== last_fill) begin bad++; $display("FAIL b2b%0d_line got=%h exp=%h", n, got, last_fill); end
            total++;
            if (ma !== {addr[31:5], 5'd0}) begin bad++; $display("FAIL b2b%0d_addr got=%h exp=%h", n, ma, {addr[31:5], 5'd0}); end
            total++;
            if ({srd, swr} !== {!wr, wr}) begin bad++; $display("FAIL b2b%0d_kind rd=%b wr=%b exp rd=%b wr=%b", n, srd, swr, !wr, wr); end
            if (wr) begin
                total++;
                if (ws !== wl || un !== 0) begin bad++; $display("FAIL b2b%0d_wdata got=%h unstable=%0d exp=%h", n, ws, un, wl); end
            end
        end
    endtask

`ifdef L2_ADAPTER_PERF_EN
    task automatic test_perf();
        int lat, tw, un, nf, nw;
        logic [255:0] got, ws;
        logic srd, swr, wr;
        logic [31:0] ma;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nf = 0; nw = 0;
        for (int n = 0; n < 5; n++) begin
            wr = (n == 1 || n == 3);
            xfer(wr, !wr, $urandom, rand_line(), rand_line(), 0, 1, 1'b0, lat, tw, got, ws, un, srd, swr, ma);
            if (wr) nw++; else nf++;
        end
        total++;
        if (fill_count_o !== 32'(nf)) begin bad++; $display("FAIL perf_fill got=%0d exp=%0d", fill_count_o, nf); end
        total++;
        if (wback_count_o !== 32'(nw)) begin bad++; $display("FAIL perf_wback got=%0d exp=%0d", wback_count_o, nw); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_wback();
        test_both();
        test_spurious();
        test_rst_mid();
        test_back_to_back();
`ifdef L2_ADAPTER_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
